// File: rtl/Constants.sv
// Datapath widths shared across the pipeline.
package Constants;
  localparam int WIDTH = 32;
  localparam int BYTE  = 8;
endpackage

// File: rtl/Decode.sv
// Load/store size-mode encodings produced by the decode stage; 2'b11 is unused.
package Decode;
  localparam logic [1:0] LoadStoreDataSizeMode_BYTE      = 2'b00;
  localparam logic [1:0] LoadStoreDataSizeMode_HALF_WORD = 2'b01;
  localparam logic [1:0] LoadStoreDataSizeMode_WORD      = 2'b10;
endpackage

// File: rtl/data_bus_pkg.sv
// Shared types and helpers for the byte-serial data bus initiator.
package data_bus_pkg;

  localparam int W = Constants::WIDTH;

  typedef enum logic [1:0] {
    State_IDLE = 2'd0,
    State_XFER = 2'd1,
    State_DONE = 2'd2
  } state_e;

  function automatic logic mode_valid(input logic [1:0] mode);
    return (mode == Decode::LoadStoreDataSizeMode_BYTE) ||
           (mode == Decode::LoadStoreDataSizeMode_HALF_WORD) ||
           (mode == Decode::LoadStoreDataSizeMode_WORD);
  endfunction

  // Big-endian lanes: narrow accesses occupy the high offsets of the word.
  function automatic logic [1:0] first_offset(input logic [1:0] mode);
    logic [1:0] off;
    case (mode)
      Decode::LoadStoreDataSizeMode_BYTE:      off = 2'd3;
      Decode::LoadStoreDataSizeMode_HALF_WORD: off = 2'd2;
      default:                                 off = 2'd0;
    endcase
    return off;
  endfunction

  function automatic logic [1:0] last_offset(input logic [1:0] mode);
    return mode_valid(mode) ? 2'd3 : 2'd0;
  endfunction

  function automatic logic [W-1:0] extend_load(input logic [W-1:0] data,
                                               input logic [1:0]   mode,
                                               input logic         sext);
    logic [W-1:0] r;
    r = '0;
    case (mode)
      Decode::LoadStoreDataSizeMode_BYTE:
        r = {{(W-8){sext & data[7]}}, data[7:0]};
      Decode::LoadStoreDataSizeMode_HALF_WORD:
        r = {{(W-16){sext & data[15]}}, data[15:0]};
      Decode::LoadStoreDataSizeMode_WORD:
        r = data;
      default:
        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_bus_byte_sequencer.sv
// Walks the byte offsets of one request over the req/ack bus with an ack timeout.
//   state      | meaning
//   State_IDLE | waiting for load/store
//   State_XFER | bus_req high for the current offset, waiting for ack
//   State_DONE | one-cycle completion pulse, error if timed out
module data_bus_byte_sequencer
  import data_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNTER_WIDTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       mode_ok_i,
  input  logic [1:0] first_off_i,
  input  logic [1:0] last_off_i,
  input  logic       bus_ack_i,
  output logic       idle_o,
  output logic       req_o,
  output logic       capture_o,
  output logic       last_o,
  output logic [1:0] offset_o,
  output logic       done_o,
  output logic       error_o
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [COUNTER_WIDTH-1:0] TMO_LAST = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                   state_q;
  logic [1:0]               offset_q;
  logic [COUNTER_WIDTH-1:0] tmo_q;
  logic                     done_q;
  logic                     error_q;
  logic                     tmo_hit;

  assign idle_o    = (state_q == State_IDLE);
  assign req_o     = (state_q == State_XFER);
  assign capture_o = req_o & bus_ack_i;
  assign last_o    = (offset_q == last_off_i);
  assign offset_o  = offset_q;
  assign done_o    = done_q;
  assign error_o   = error_q;

  // An ack arriving on the final allowed cycle still wins over the timeout.
  assign tmo_hit = TMO_EN && req_o && !bus_ack_i && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= State_IDLE;
      offset_q <= 2'd0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        State_IDLE: begin
          if (start_i) begin
            tmo_q <= '0;
            if (mode_ok_i) begin
              offset_q <= first_off_i;
              state_q  <= State_XFER;
            end else begin
              done_q  <= 1'b1;
              state_q <= State_DONE;
            end
          end
        end
        State_XFER: begin
          if (bus_ack_i) begin
            tmo_q <= '0;
            if (offset_q == last_off_i) begin
              done_q  <= 1'b1;
              state_q <= State_DONE;
            end else begin
              offset_q <= offset_q + 2'd1;
            end
          end else if (tmo_hit) begin
            tmo_q   <= '0;
            done_q  <= 1'b1;
            error_q <= 1'b1;
            state_q <= State_DONE;
          end else if (TMO_EN) begin
            tmo_q <= tmo_q + COUNTER_WIDTH'(1);
          end
        end
        State_DONE: begin
          done_q   <= 1'b0;
          error_q  <= 1'b0;
          offset_q <= 2'd0;
          state_q  <= State_IDLE;
        end
        default: begin
          done_q   <= 1'b0;
          error_q  <= 1'b0;
          offset_q <= 2'd0;
          tmo_q    <= '0;
          state_q  <= State_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/data_bus_initiator.sv
// Turns one memory-stage load/store into big-endian byte transfers on a req/ack bus,
// stalling the pipeline until the assembled, extended result is ready.
module data_bus_initiator
  import data_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNTER_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       store,
  input  logic [1:0]                 load_store_data_size_mode,
  input  logic                       load_sign_extend,
  input  logic [Constants::WIDTH-1:0] address,
  input  logic [Constants::WIDTH-1:0] write_data,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [Constants::WIDTH-1:0] read_data,
  output logic                       bus_req,
  output logic                       bus_we,
  output logic [Constants::WIDTH-1:0] bus_addr,
  output logic [Constants::BYTE-1:0]  bus_wdata,
  input  logic [Constants::BYTE-1:0]  bus_rdata,
  input  logic                       bus_ack
);

  localparam int B = Constants::BYTE;

  logic       start;
  logic       accept;
  logic       seq_idle;
  logic       seq_req;
  logic       capture;
  logic       last;
  logic       seq_done;
  logic       seq_error;
  logic [1:0] offset;
  logic [1:0] lane_idx;
  logic       mode_ok;
  logic [1:0] first_off;
  logic [1:0] last_off;

  logic [W-1:0]        addr_q;
  logic [3:0][B-1:0]   wlanes_q;
  logic [3:0][B-1:0]   rlanes_q;
  logic [3:0][B-1:0]   rlanes_d;
  logic [1:0]          mode_q;
  logic                sext_q;
  logic                we_q;
  logic [W-1:0]        read_data_q;
  logic [W-1:0]        read_data_d;

  assign start     = load | store;
  assign accept    = seq_idle & start;
  assign mode_ok   = mode_valid(load_store_data_size_mode);
  assign first_off = first_offset(load_store_data_size_mode);
  assign last_off  = last_offset(mode_q);
  // Offset 0 is the most significant byte, i.e. lane 3 of the packed word.
  assign lane_idx  = ~offset;

  data_bus_byte_sequencer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .COUNTER_WIDTH  (COUNTER_WIDTH)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .mode_ok_i   (mode_ok),
    .first_off_i (first_off),
    .last_off_i  (last_off),
    .bus_ack_i   (bus_ack),
    .idle_o      (seq_idle),
    .req_o       (seq_req),
    .capture_o   (capture),
    .last_o      (last),
    .offset_o    (offset),
    .done_o      (seq_done),
    .error_o     (seq_error)
  );

  always_comb begin
    rlanes_d = rlanes_q;
    if (capture && !we_q) begin
      rlanes_d[lane_idx] = bus_rdata;
    end
  end

  // Result is formed on the final ack so it lines up with the done pulse.
  assign read_data_d = (capture && last && !we_q) ? extend_load(rlanes_d, mode_q, sext_q) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      wlanes_q    <= '0;
      rlanes_q    <= '0;
      mode_q      <= 2'd0;
      sext_q      <= 1'b0;
      we_q        <= 1'b0;
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
      rlanes_q    <= rlanes_d;
      if (accept) begin
        addr_q   <= address;
        wlanes_q <= write_data;
        mode_q   <= load_store_data_size_mode;
        sext_q   <= load_sign_extend;
        we_q     <= store;
        rlanes_q <= '0;
      end
    end
  end

  assign busy      = seq_idle ? start : seq_req;
  assign done      = seq_done;
  assign error     = seq_error;
  assign read_data = read_data_q;
  assign bus_req   = seq_req;
  assign bus_we    = seq_req & we_q;
  assign bus_addr  = seq_req ? (addr_q + W'(offset)) : '0;
  assign bus_wdata = (seq_req && we_q) ? wlanes_q[lane_idx] : '0;

endmodule

// File: tb/tb_data_bus_initiator.sv
// Scoreboard bench: expected bus bytes and completions are queued at issue time and
// consumed by an independent monitor on the falling clock edge.
module tb_data_bus_initiator;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } bus_exp_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          cyc;
    int          reqs;
  } done_exp_t;

  localparam logic [1:0] M_BYTE = Decode::LoadStoreDataSizeMode_BYTE;
  localparam logic [1:0] M_HALF = Decode::LoadStoreDataSizeMode_HALF_WORD;
  localparam logic [1:0] M_WORD = Decode::LoadStoreDataSizeMode_WORD;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, store, load_sign_extend;
  logic [1:0]  load_store_data_size_mode;
  logic [31:0] address, write_data;
  logic        busy, done, error;
  logic [31:0] read_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;

  bus_exp_t  exp_bus_q[$];
  done_exp_t exp_done_q[$];
  logic [7:0] rd_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int req_run  = 0;
  int ack_delay = 0;
  bit no_ack    = 1'b0;

  data_bus_initiator #(.TIMEOUT_CYCLES(4), .COUNTER_WIDTH(8)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .load                      (load),
    .store                     (store),
    .load_store_data_size_mode (load_store_data_size_mode),
    .load_sign_extend          (load_sign_extend),
    .address                   (address),
    .write_data                (write_data),
    .busy                      (busy),
    .done                      (done),
    .error                     (error),
    .read_data                 (read_data),
    .bus_req                   (bus_req),
    .bus_we                    (bus_we),
    .bus_addr                  (bus_addr),
    .bus_wdata                 (bus_wdata),
    .bus_rdata                 (bus_rdata),
    .bus_ack                   (bus_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endfunction

  task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [7:0] wd);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wd;
    exp_bus_q.push_back(e);
  endtask

  // Bus slave: acks after ack_delay wait cycles, returning queued read bytes.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_rdata = 8'h00;
      if (rst && bus_req && !no_ack) begin
        if (wait_cnt >= ack_delay) begin
          bus_ack  = 1'b1;
          wait_cnt = 0;
          if (rd_q.size() > 0) bus_rdata = rd_q.pop_front();
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    bus_exp_t  be;
    done_exp_t de;
    forever begin
      @(negedge clk);
      if (!rst) begin
        req_run = 0;
      end else begin
        if (bus_req) begin
          req_run++;
          chk("busy_in_xfer", busy, 1);
          if (exp_bus_q.size() == 0) begin
            chk("unexpected_bus_req", bus_req, 0);
          end else begin
            be = exp_bus_q[0];
            chk("bus_we", bus_we, be.we);
            chk("bus_addr", bus_addr, be.addr);
            if (be.we) chk("bus_wdata", bus_wdata, be.wdata);
            if (bus_ack) void'(exp_bus_q.pop_front());
          end
        end
        if (done) begin
          chk("busy_in_done", busy, 0);
          chk("req_in_done", bus_req, 0);
          if (exp_done_q.size() == 0) begin
            chk("unexpected_done", done, 0);
          end else begin
            de = exp_done_q.pop_front();
            chk("error", error, de.err);
            chk("read_data", read_data, de.rd);
            chk("done_cycle", cyc, de.cyc);
            chk("req_cycles", req_run, de.reqs);
          end
          req_run = 0;
        end
      end
    end
  end

  task automatic run_req(input logic ld, input logic st, input logic [1:0] mode, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input int delay,
                         input bit noack, input bit scramble, input logic exp_err,
                         input logic [31:0] exp_rd, input int exp_lat, input int exp_reqs);
    done_exp_t de;
    bit seen;
    ack_delay = delay;
    no_ack    = noack;
    @(posedge clk); #1;
    load = ld; store = st; load_store_data_size_mode = mode;
    load_sign_extend = sx; address = a; write_data = wd;
    de.err = exp_err; de.rd = exp_rd; de.cyc = cyc + exp_lat - 1; de.reqs = exp_reqs;
    exp_done_q.push_back(de);
    @(negedge clk);
    chk("busy_on_accept", busy, 1);
    chk("req_on_accept", bus_req, 0);
    @(posedge clk); #1;
    if (scramble) begin
      address = 32'hDEAD0000; write_data = 32'h0;
      load_store_data_size_mode = M_BYTE; load_sign_extend = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL done_wait: no done within 100 cycles for addr 0x%08h", a);
      exp_done_q.delete(); exp_bus_q.delete(); rd_q.delete();
    end
    @(posedge clk); #1;
    load = 1'b0; store = 1'b0;
    no_ack = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b0; load = 1'b0; store = 1'b0; load_sign_extend = 1'b0;
    load_store_data_size_mode = M_BYTE; address = '0; write_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_bus_req", bus_req, 0);
    end

    // Store WORD, back-to-back acks
    exp_bus(1, 32'h100, 8'hDE); exp_bus(1, 32'h101, 8'hAD);
    exp_bus(1, 32'h102, 8'hBE); exp_bus(1, 32'h103, 8'hEF);
    run_req(0, 1, M_WORD, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 6, 4);

    // Load BYTE sign-extended
    exp_bus(0, 32'h43, 8'h00); rd_q.push_back(8'h80);
    run_req(1, 0, M_BYTE, 1, 32'h40, 32'h0, 0, 0, 0, 0, 32'hFFFFFF80, 3, 1);

    // Load HALF zero-extended, 3 wait cycles per byte
    exp_bus(0, 32'h22, 8'h00); exp_bus(0, 32'h23, 8'h00);
    rd_q.push_back(8'h12); rd_q.push_back(8'h34);
    run_req(1, 0, M_HALF, 0, 32'h20, 32'h0, 3, 0, 0, 0, 32'h00001234, 10, 8);

    // Load WORD with no ack: timeout after 4 request cycles
    exp_bus(0, 32'h80, 8'h00);
    run_req(1, 0, M_WORD, 0, 32'h80, 32'h0, 0, 1, 0, 1, 32'h0, 6, 4);
    exp_bus_q.delete();

    // Load HALF sign-extended across address wrap
    exp_bus(0, 32'h0, 8'h00); exp_bus(0, 32'h1, 8'h00);
    rd_q.push_back(8'h80); rd_q.push_back(8'h01);
    run_req(1, 0, M_HALF, 1, 32'hFFFFFFFE, 32'h0, 0, 0, 0, 0, 32'hFFFF8001, 4, 2);

    // Load WORD, one wait per byte, inputs scrambled after acceptance
    exp_bus(0, 32'h1000, 8'h00); exp_bus(0, 32'h1001, 8'h00);
    exp_bus(0, 32'h1002, 8'h00); exp_bus(0, 32'h1003, 8'h00);
    rd_q.push_back(8'h01); rd_q.push_back(8'h02); rd_q.push_back(8'h03); rd_q.push_back(8'h04);
    run_req(1, 0, M_WORD, 0, 32'h1000, 32'h0, 1, 0, 1, 0, 32'h01020304, 10, 8);

    // Load BYTE zero-extended
    exp_bus(0, 32'hA, 8'h00); rd_q.push_back(8'hF0);
    run_req(1, 0, M_BYTE, 0, 32'h7, 32'h0, 0, 0, 0, 0, 32'h000000F0, 3, 1);

    // Load and store together: store wins
    exp_bus(1, 32'h53, 8'h78); rd_q.push_back(8'h99);
    run_req(1, 1, M_BYTE, 1, 32'h50, 32'h12345678, 0, 0, 0, 0, 32'h0, 3, 1);

    // Invalid size mode: no bus activity
    run_req(1, 0, 2'b11, 0, 32'h60, 32'h0, 0, 0, 0, 0, 32'h0, 2, 0);

    // Store HALF
    exp_bus(1, 32'h12, 8'hBA); exp_bus(1, 32'h13, 8'hBE);
    run_req(0, 1, M_HALF, 0, 32'h10, 32'hCAFEBABE, 0, 0, 0, 0, 32'h0, 4, 2);

    // Reset during the second byte of a WORD store
    ack_delay = 2;
    exp_bus(1, 32'h200, 8'h11); exp_bus(1, 32'h201, 8'h22);
    exp_bus(1, 32'h202, 8'h33); exp_bus(1, 32'h203, 8'h44);
    @(posedge clk); #1;
    store = 1'b1; load_store_data_size_mode = M_WORD; address = 32'h200; write_data = 32'h11223344;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_req && bus_addr == 32'h201) begin found = 1'b1; break; end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL reset_wait: second byte never requested");
    end
    #2;
    rst = 1'b0; store = 1'b0;
    #1;
    chk("midrst_bus_req", bus_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_bus_we", bus_we, 0);
    chk("midrst_bus_addr", bus_addr, 0);
    exp_bus_q.delete(); exp_done_q.delete(); rd_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;

    // Fresh request after reset starts at offset 0
    exp_bus(1, 32'h300, 8'hA1); exp_bus(1, 32'h301, 8'hB2);
    exp_bus(1, 32'h302, 8'hC3); exp_bus(1, 32'h303, 8'hD4);
    run_req(0, 1, M_WORD, 0, 32'h300, 32'hA1B2C3D4, 0, 0, 0, 0, 32'h0, 6, 4);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("left_done_exp", exp_done_q.size(), 0);
    chk("left_bus_exp", exp_bus_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_bus_initiator.md
Name: data_bus_initiator

Overview:
- Initiator-side counterpart to the pipeline's load/store data memory.
- Takes one load/store request per instruction from the memory stage, in the same signal form the stage already produces: load, store, size mode, sign extend, address, write data.
- Executes the request as a sequence of byte transfers on an external req/ack byte bus.
- Holds the pipeline stall while busy, then returns assembled and extended read data for the memory buffer.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for bus_ack on one byte before abort; 0 disables the timeout.
- COUNTER_WIDTH, 8: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**COUNTER_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- load  in  1  load request (level, held by the pipeline while stalled)
- store  in  1  store request (level)
- load_store_data_size_mode  in  2  Decode::LoadStoreDataSizeMode_{BYTE,HALF_WORD,WORD}
- load_sign_extend  in  1  sign-extend BYTE/HALF_WORD loads
- address  in  Constants::WIDTH  base byte address
- write_data  in  Constants::WIDTH  store data
- busy  out  1  stall request to the pipeline
- done  out  1  one-cycle completion pulse
- error  out  1  timeout abort flag, valid with done
- read_data  out  Constants::WIDTH  load result, valid while done=1
- bus_req  out  1  byte transfer request
- bus_we  out  1  1=write, 0=read
- bus_addr  out  Constants::WIDTH  byte address
- bus_wdata  out  Constants::BYTE  write byte
- bus_rdata  in  Constants::BYTE  read byte, valid with bus_ack
- bus_ack  in  1  transfer complete, sampled at posedge clk

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - All outputs 0; read_data holding register 0; byte index 0; timeout counter 0.
- Byte map (big-endian, identical to the existing data memory):
  - WORD: offsets 0,1,2,3 carry data[31:24], [23:16], [15:8], [7:0].
  - HALF_WORD: offsets 2,3 carry data[15:8], [7:0].
  - BYTE: offset 3 carries data[7:0].
  - bus_addr = address + offset, modulo 2**WIDTH.
- States: IDLE, XFER, DONE.
- IDLE:
  - If load|store, latch address, write_data, mode, sign extend and direction; set first offset; go to XFER.
  - busy = (load|store) combinationally in IDLE; no bus activity in this cycle.
  - load and store both asserted: store wins and the load is ignored.
  - Invalid mode (2'b11): no transfer; go to DONE with error=0 and read_data=0.
- XFER:
  - bus_req=1; bus_we, bus_addr and bus_wdata are stable until ack.
  - On bus_ack:
    - Read: capture bus_rdata into the byte lane for the current offset.
    - Last offset: go to DONE. Otherwise advance to the next offset; bus_req stays 1 (back-to-back allowed).
  - Timeout counter increments each XFER cycle without ack and clears on ack. Reaching TIMEOUT_CYCLES: set error, drop bus_req, go to DONE.
  - busy=1 throughout.
- DONE:
  - Exactly one cycle: done=1, busy=0, bus_req=0.
  - read_data = assembled lanes; upper bits zero, or replicated from bit 7 (BYTE) / bit 15 (HALF_WORD) if sign extend is set. Stores give read_data=0.
  - On error, read_data=0.
  - Next state is always IDLE; the still-present request is not re-accepted in DONE.
- Latency: one ack per byte. The minimum cycle counts below include the IDLE accept cycle:
  - BYTE: 3 cycles.
  - HALF_WORD: 4 cycles.
  - WORD: 6 cycles.
- Input changes after acceptance are ignored (latched).
- Reset mid-transfer: bus_req drops immediately; no done pulse.

Decomposition:
- Shared package data_bus_pkg holds:
  - typedef enum State_IDLE/State_XFER/State_DONE
  - a function giving first/last offset per size mode
  - a function for the sign/zero extension of assembled data
- Size-mode encodings stay in Decode; widths stay in Constants.
- Natural sub-module: data_bus_byte_sequencer (offset counter, timeout counter, req/ack tracking).
- The top level keeps request latching, lane assembly and extension.

Test Plan:
- Reset then idle with load=store=0 -> busy=0, bus_req=0, done never pulses.
- Store WORD, addr 0x100, data 0xDEADBEEF, ack each cycle -> writes 0xDE@0x100, 0xAD@0x101, 0xBE@0x102, 0xEF@0x103; done on cycle 6.
- Load BYTE sign-extend, addr 0x40, rdata 0x80 at 0x43 -> single read of 0x43; read_data=0xFFFFFF80 with done on cycle 3.
- Load HALF_WORD zero-extend, addr 0x20, rdata 0x12@0x22 and 0x34@0x23, ack delayed 3 cycles each -> bus_req held steady during waits; read_data=0x00001234.
- Load WORD, TIMEOUT_CYCLES=4, no ack -> bus_req for 4 cycles, then done=1, error=1, read_data=0.
- Assert rst during the 2nd byte of a WORD store -> outputs 0 immediately; the next request starts at offset 0.
